// File: rtl/dram_word_port.sv
// Purpose     : word-granular (32-bit) load/store front end for the DDR3 wrapper user port;
//               packs stores into masked 128-bit line writes and cuts read lines back to one word.
// Latency     : command issues the cycle after acceptance; load data 1 cycle after i_dram_valid.
// Backpressure: o_ready drops while the held request cannot issue (i_dram_busy, or 8 reads outstanding).
// Ports       : clk/i_rst (async, active high); i_valid/o_ready request handshake with
//               i_wen/i_addr/i_wdata/i_wstrb; o_rvalid/o_rdata load response; o_idle, o_err (sticky);
//               o_dram_* command side to the wrapper; i_dram_busy/i_dram_data/i_dram_valid from it.
module dram_word_port #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16,
  parameter int RD_ADDR_WIDTH  = 3
) (
  input  logic                      clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  input  logic                      i_wen,
  input  logic [31:0]               i_addr,
  input  logic [31:0]               i_wdata,
  input  logic [3:0]                i_wstrb,
  output logic                      o_ready,
  output logic [31:0]               o_rdata,
  output logic                      o_rvalid,
  output logic                      o_idle,
  output logic                      o_err,
  output logic                      o_dram_ren,
  output logic                      o_dram_wen,
  output logic [APP_ADDR_WIDTH-2:0] o_dram_addr,
  output logic [APP_DATA_WIDTH-1:0] o_dram_data,
  output logic [APP_MASK_WIDTH-1:0] o_dram_mask,
  output logic                      o_dram_busy,
  input  logic                      i_dram_busy,
  input  logic [APP_DATA_WIDTH-1:0] i_dram_data,
  input  logic                      i_dram_valid
);

  localparam int DEPTH = 1 << RD_ADDR_WIDTH;
  localparam int PW    = RD_ADDR_WIDTH + 1;

  // Request holding register
  logic                      req_full_q, req_full_d;
  logic                      req_wen_q,  req_wen_d;
  logic [APP_ADDR_WIDTH-2:0] req_addr_q, req_addr_d;
  logic [1:0]                req_off_q,  req_off_d;
  logic [31:0]               req_data_q, req_data_d;
  logic [3:0]                req_strb_q, req_strb_d;

  // Outstanding-read word offsets, oldest at rd_ptr
  logic [1:0]    ofifo_mem_q [DEPTH];
  logic [1:0]    ofifo_mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  // Response / status registers
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q,  rdata_d;
  logic          err_q,    err_d;

  logic [PW-1:0] ofifo_count;
  logic          ofifo_full;
  logic          ofifo_empty;
  logic          fire;
  logic          accept;
  logic          push;
  logic          pop;
  logic [1:0]    rd_off;
  logic [31:0]   rd_word;
  logic [APP_MASK_WIDTH-1:0] dram_mask;
  logic          unused_bits;

  // Pointers carry one extra bit so full (difference == DEPTH) and empty (== 0) are distinct.
  assign ofifo_count = wr_ptr_q - rd_ptr_q;
  assign ofifo_full  = (ofifo_count == PW'(DEPTH));
  assign ofifo_empty = (ofifo_count == '0);

  // Stores need no offset slot; loads only issue when their offset can be recorded.
  assign fire   = req_full_q && !i_dram_busy && (req_wen_q || !ofifo_full);
  assign accept = i_valid && o_ready;
  assign push   = fire && !req_wen_q;
  assign pop    = i_dram_valid && !ofifo_empty;

  assign rd_off  = ofifo_mem_q[rd_ptr_q[RD_ADDR_WIDTH-1:0]];
  assign rd_word = i_dram_data[{rd_off, 5'b00000} +: 32];

  // Only the addressed word's bytes may be written; every other byte stays masked (1).
  always_comb begin
    dram_mask = '1;
    dram_mask[{req_off_q, 2'b00} +: 4] = ~req_strb_q;
  end

  always_comb begin
    req_full_d = req_full_q;
    req_wen_d  = req_wen_q;
    req_addr_d = req_addr_q;
    req_off_d  = req_off_q;
    req_data_d = req_data_q;
    req_strb_d = req_strb_q;
    if (accept) begin
      req_full_d = 1'b1;
      req_wen_d  = i_wen;
      // Line address in 16-bit column units: 8 columns per 128-bit line.
      req_addr_d = {i_addr[APP_ADDR_WIDTH-1:4], 3'b000};
      req_off_d  = i_addr[3:2];
      req_data_d = i_wdata;
      req_strb_d = i_wstrb;
    end else if (fire) begin
      req_full_d = 1'b0;
    end

    ofifo_mem_d = ofifo_mem_q;
    if (push) begin
      ofifo_mem_d[wr_ptr_q[RD_ADDR_WIDTH-1:0]] = req_off_q;
    end
    wr_ptr_d = wr_ptr_q + {{RD_ADDR_WIDTH{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{RD_ADDR_WIDTH{1'b0}}, pop};

    rvalid_d = pop;
    rdata_d  = pop ? rd_word : rdata_q;
    // Data with nothing outstanding is dropped and flagged until reset.
    err_d    = err_q | (i_dram_valid & ofifo_empty);
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      req_full_q  <= 1'b0;
      req_wen_q   <= 1'b0;
      req_addr_q  <= '0;
      req_off_q   <= '0;
      req_data_q  <= '0;
      req_strb_q  <= '0;
      ofifo_mem_q <= '{default: 2'b00};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      req_full_q  <= req_full_d;
      req_wen_q   <= req_wen_d;
      req_addr_q  <= req_addr_d;
      req_off_q   <= req_off_d;
      req_data_q  <= req_data_d;
      req_strb_q  <= req_strb_d;
      ofifo_mem_q <= ofifo_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign o_ready     = !req_full_q || fire;
  assign o_rdata     = rdata_q;
  assign o_rvalid    = rvalid_q;
  assign o_idle      = !req_full_q && ofifo_empty;
  assign o_err       = err_q;
  assign o_dram_ren  = fire && !req_wen_q;
  assign o_dram_wen  = fire && req_wen_q;
  assign o_dram_addr = req_addr_q;
  assign o_dram_data = {(APP_DATA_WIDTH/32){req_data_q}};
  assign o_dram_mask = dram_mask;
  // Responses are always sunk, so the wrapper is never stalled.
  assign o_dram_busy = 1'b0;

  // Byte-lane bits and address bits above the DRAM range carry no meaning here.
  assign unused_bits = ^{i_addr[31:APP_ADDR_WIDTH], i_addr[1:0]};

endmodule

// File: tb/tb_dram_word_port.sv
// Purpose     : self-checking bench for dram_word_port with a scoreboard of expected load words.
// Latency     : checks command issue one cycle after acceptance and load data one cycle after i_dram_valid.
// Backpressure: exercises i_dram_busy stalls and a full outstanding-read queue.
module tb_dram_word_port;

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_wen = 1'b0;
  logic [31:0]  i_addr = '0;
  logic [31:0]  i_wdata = '0;
  logic [3:0]   i_wstrb = '0;
  logic         o_ready;
  logic [31:0]  o_rdata;
  logic         o_rvalid;
  logic         o_idle;
  logic         o_err;
  logic         o_dram_ren;
  logic         o_dram_wen;
  logic [26:0]  o_dram_addr;
  logic [127:0] o_dram_data;
  logic [15:0]  o_dram_mask;
  logic         o_dram_busy;
  logic         i_dram_busy = 1'b0;
  logic [127:0] i_dram_data = '0;
  logic         i_dram_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  int ren_cnt = 0;
  int wen_cnt = 0;
  int viol_cnt = 0;
  logic [26:0] wen_log[$];

  dram_word_port dut (
    .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_wen(i_wen), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .o_ready(o_ready), .o_rdata(o_rdata),
    .o_rvalid(o_rvalid), .o_idle(o_idle), .o_err(o_err), .o_dram_ren(o_dram_ren),
    .o_dram_wen(o_dram_wen), .o_dram_addr(o_dram_addr), .o_dram_data(o_dram_data),
    .o_dram_mask(o_dram_mask), .o_dram_busy(o_dram_busy), .i_dram_busy(i_dram_busy),
    .i_dram_data(i_dram_data), .i_dram_valid(i_dram_valid)
  );

  always #5 clk = ~clk;

  // Command-side observers, sampled mid-cycle.
  always @(negedge clk) begin
    if (!i_rst) begin
      if (o_dram_ren) ren_cnt <= ren_cnt + 1;
      if (o_dram_wen) begin
        wen_cnt <= wen_cnt + 1;
        wen_log.push_back(o_dram_addr);
      end
      if (i_dram_busy && (o_dram_ren || o_dram_wen)) viol_cnt <= viol_cnt + 1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_valid = 1'b0;
    i_dram_valid = 1'b0;
    i_dram_busy = 1'b0;
    exp_q.delete();
    cyc();
    cyc();
    i_rst = 1'b0;
    cyc();
  endtask

  task automatic send(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, output bit ok);
    ok = 1'b0;
    i_valid = 1'b1;
    i_wen = wen;
    i_addr = addr;
    i_wdata = wd;
    i_wstrb = st;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (o_ready) ok = 1'b1;
      cyc();
    end
    i_valid = 1'b0;
  endtask

  function automatic logic [127:0] resp_line(int j);
    logic [31:0] b;
    b = 32'hA000_0000 + 32'(j);
    return {b + 32'h3000_0000, b + 32'h2000_0000, b + 32'h1000_0000, b};
  endfunction

  task automatic test_reset();
    i_rst = 1'b1;
    cyc();
    @(negedge clk);
    checks++; if (o_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", o_rvalid); end
    checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", o_rdata); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", o_err); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", o_ready); end
    checks++; if (o_idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", o_idle); end
    checks++; if ({o_dram_ren, o_dram_wen, o_dram_busy} !== 3'b000)
      begin errors++; $display("FAIL reset_cmd got %b want 000", {o_dram_ren, o_dram_wen, o_dram_busy}); end
    do_reset();
  endtask

  task automatic test_store();
    bit ok;
    do_reset();
    send(1'b1, 32'h0000_0014, 32'hDEADBEEF, 4'b0011, ok);
    checks++; if (!ok) begin errors++; $display("FAIL store_accept timed out"); end
    @(negedge clk);
    checks++; if ({o_dram_wen, o_dram_ren} !== 2'b10)
      begin errors++; $display("FAIL store_cmd got wen/ren %b want 10", {o_dram_wen, o_dram_ren}); end
    checks++; if (o_dram_addr !== 27'h8) begin errors++; $display("FAIL store_addr got %h want 8", o_dram_addr); end
    checks++; if (o_dram_mask !== 16'hFFCF) begin errors++; $display("FAIL store_mask got %h want ffcf", o_dram_mask); end
    checks++; if (o_dram_data !== {4{32'hDEADBEEF}})
      begin errors++; $display("FAIL store_data got %h want 4xdeadbeef", o_dram_data); end
    cyc();
    @(negedge clk);
    checks++; if (o_dram_wen !== 1'b0) begin errors++; $display("FAIL store_one_cycle got wen %b want 0", o_dram_wen); end
    checks++; if (o_idle !== 1'b1) begin errors++; $display("FAIL store_idle got %b want 1", o_idle); end
    cyc();
  endtask

  task automatic test_load();
    bit ok;
    logic [31:0] w;
    do_reset();
    send(1'b0, 32'h0000_0028, 32'h0, 4'h0, ok);
    exp_q.push_back(32'hAAAA_0002);
    checks++; if (!ok) begin errors++; $display("FAIL load_accept timed out"); end
    @(negedge clk);
    checks++; if (o_dram_ren !== 1'b1) begin errors++; $display("FAIL load_ren got %b want 1", o_dram_ren); end
    checks++; if (o_dram_addr !== 27'h10) begin errors++; $display("FAIL load_addr got %h want 10", o_dram_addr); end
    cyc();
    @(negedge clk);
    checks++; if (o_idle !== 1'b0) begin errors++; $display("FAIL load_busy_idle got %b want 0", o_idle); end
    cyc();
    i_dram_valid = 1'b1;
    i_dram_data = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
    @(negedge clk);
    checks++; if (o_rvalid !== 1'b0) begin errors++; $display("FAIL load_latency got rvalid %b want 0", o_rvalid); end
    cyc();
    i_dram_valid = 1'b0;
    @(negedge clk);
    checks++; if (o_rvalid !== 1'b1) begin errors++; $display("FAIL load_rvalid got %b want 1", o_rvalid); end
    if (o_rvalid === 1'b1 && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      checks++; if (o_rdata !== w) begin errors++; $display("FAIL load_rdata got %h want %h", o_rdata, w); end
    end
    cyc();
    @(negedge clk);
    checks++; if ({o_rvalid, o_idle} !== 2'b01)
      begin errors++; $display("FAIL load_after got rvalid/idle %b want 01", {o_rvalid, o_idle}); end
    cyc();
  endtask

  task automatic test_busy_hold();
    bit ok;
    int wbase, lbase, held;
    bit got;
    do_reset();
    wbase = wen_cnt;
    lbase = wen_log.size();
    i_dram_busy = 1'b1;
    send(1'b1, 32'h0000_0100, 32'h1111_1111, 4'hF, ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_first_accept timed out"); end
    i_valid = 1'b1; i_wen = 1'b1; i_addr = 32'h0000_0200; i_wdata = 32'h2222_2222; i_wstrb = 4'hF;
    held = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (!o_ready) held++;
      cyc();
    end
    checks++; if (held !== 9) begin errors++; $display("FAIL busy_ready_low got %0d cycles want 9", held); end
    checks++; if (wen_cnt - wbase !== 0) begin errors++; $display("FAIL busy_no_issue got %0d writes want 0", wen_cnt - wbase); end
    i_dram_busy = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (o_ready) got = 1'b1;
      cyc();
    end
    i_valid = 1'b0;
    cyc(); cyc(); cyc();
    checks++; if (!got) begin errors++; $display("FAIL busy_second_accept timed out"); end
    checks++; if (wen_cnt - wbase !== 2) begin errors++; $display("FAIL busy_release got %0d writes want 2", wen_cnt - wbase); end
    if (wen_log.size() >= lbase + 2) begin
      checks++; if (wen_log[lbase] !== 27'h80) begin errors++; $display("FAIL busy_order0 got %h want 80", wen_log[lbase]); end
      checks++; if (wen_log[lbase+1] !== 27'h100) begin errors++; $display("FAIL busy_order1 got %h want 100", wen_log[lbase+1]); end
    end
    checks++; if (viol_cnt !== 0) begin errors++; $display("FAIL busy_violation got %0d want 0", viol_cnt); end
  endtask

  task automatic test_ofifo_full();
    bit ok, all_ok;
    int rbase, got, j;
    logic [31:0] w;
    do_reset();
    rbase = ren_cnt;
    all_ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(1'b0, 32'(i * 16 + (i % 4) * 4), 32'h0, 4'h0, ok);
      if (!ok) all_ok = 1'b0;
      exp_q.push_back(32'hA000_0000 + 32'(i) + 32'(i % 4) * 32'h1000_0000);
    end
    checks++; if (!all_ok) begin errors++; $display("FAIL full_accept timed out"); end
    cyc(); cyc(); cyc();
    checks++; if (ren_cnt - rbase !== 8) begin errors++; $display("FAIL full_issued got %0d want 8", ren_cnt - rbase); end
    @(negedge clk);
    checks++; if ({o_ready, o_idle} !== 2'b00)
      begin errors++; $display("FAIL full_ready got ready/idle %b want 00", {o_ready, o_idle}); end
    cyc();
    i_dram_valid = 1'b1;
    i_dram_data = resp_line(0);
    @(negedge clk);
    checks++; if (o_dram_ren !== 1'b0) begin errors++; $display("FAIL full_hold got ren %b want 0", o_dram_ren); end
    cyc();
    i_dram_valid = 1'b0;
    @(negedge clk);
    checks++; if (o_dram_ren !== 1'b1) begin errors++; $display("FAIL full_refire got ren %b want 1", o_dram_ren); end
    got = 0;
    if (o_rvalid === 1'b1 && exp_q.size() > 0) begin
      got++;
      w = exp_q.pop_front();
      checks++; if (o_rdata !== w) begin errors++; $display("FAIL full_rdata0 got %h want %h", o_rdata, w); end
    end
    j = 1;
    for (int c = 0; c < 14; c++) begin
      cyc();
      if (j <= 8) begin
        i_dram_valid = 1'b1;
        i_dram_data = resp_line(j);
        j++;
      end else begin
        i_dram_valid = 1'b0;
      end
      @(negedge clk);
      if (o_rvalid === 1'b1) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL full_extra rvalid got data %h want none", o_rdata);
        end else begin
          w = exp_q.pop_front();
          if (o_rdata !== w) begin errors++; $display("FAIL full_rdata got %h want %h", o_rdata, w); end
        end
      end
    end
    checks++; if (got !== 9) begin errors++; $display("FAIL full_resp_count got %0d want 9", got); end
    checks++; if (o_idle !== 1'b1) begin errors++; $display("FAIL full_drain_idle got %b want 1", o_idle); end
    cyc();
  endtask

  task automatic test_err_reset();
    bit ok;
    int stale;
    do_reset();
    i_dram_valid = 1'b1;
    i_dram_data = resp_line(7);
    cyc();
    i_dram_valid = 1'b0;
    @(negedge clk);
    checks++; if ({o_err, o_rvalid} !== 2'b10)
      begin errors++; $display("FAIL err_set got err/rvalid %b want 10", {o_err, o_rvalid}); end
    cyc(); cyc(); cyc();
    @(negedge clk);
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", o_err); end
    cyc();
    send(1'b0, 32'h0000_0040, 32'h0, 4'h0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL err_load_accept timed out"); end
    cyc();
    i_rst = 1'b1;
    #2;
    checks++; if ({o_err, o_idle, o_rvalid, o_ready} !== 4'b0101)
      begin errors++; $display("FAIL err_reset got err/idle/rvalid/ready %b want 0101", {o_err, o_idle, o_rvalid, o_ready}); end
    cyc();
    i_rst = 1'b0;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (o_rvalid === 1'b1) stale++;
      cyc();
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL err_stale_rvalid got %0d want 0", stale); end
    checks++; if (o_idle !== 1'b1) begin errors++; $display("FAIL err_post_idle got %b want 1", o_idle); end
  endtask

  task automatic test_random();
    logic [31:0]  ref_mem[int];
    logic [127:0] dram_mem[int];
    int           pend_due[$];
    logic [127:0] pend_dat[$];
    logic [127:0] line;
    logic [31:0]  word, w;
    int accepted, cycle, last_due, due, vbase;
    bit acc_now;
    localparam int N = 2000;
    do_reset();
    vbase = viol_cnt;
    accepted = 0; cycle = 0; last_due = 0; acc_now = 1'b0;
    while ((accepted < N || exp_q.size() != 0 || pend_due.size() != 0) && cycle < 30000) begin
      if (acc_now || !i_valid) begin
        i_valid = 1'b0;
        if (accepted < N && $urandom_range(0, 3) != 0) begin
          i_valid = 1'b1;
          i_wen = $urandom_range(0, 1) == 1;
          i_addr = (32'($urandom_range(0, 15)) << 28) | (32'($urandom_range(0, 31)) << 4) |
                   (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
          i_wdata = $urandom;
          i_wstrb = 4'($urandom_range(0, 15));
        end
      end
      acc_now = 1'b0;
      i_dram_busy = ($urandom_range(0, 4) == 0);
      if (pend_due.size() > 0 && pend_due[0] <= cycle) begin
        void'(pend_due.pop_front());
        i_dram_valid = 1'b1;
        i_dram_data = pend_dat.pop_front();
      end else begin
        i_dram_valid = 1'b0;
      end
      @(negedge clk);
      if (o_rvalid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra rvalid got %h want none", o_rdata);
        end else begin
          w = exp_q.pop_front();
          if (o_rdata !== w) begin errors++; $display("FAIL rand_rdata got %h want %h", o_rdata, w); end
        end
      end
      if (o_dram_wen === 1'b1) begin
        line = dram_mem.exists(int'(o_dram_addr >> 3)) ? dram_mem[int'(o_dram_addr >> 3)] : 128'h0;
        for (int b = 0; b < 16; b++)
          if (!o_dram_mask[b]) line[8*b +: 8] = o_dram_data[8*b +: 8];
        dram_mem[int'(o_dram_addr >> 3)] = line;
      end
      if (o_dram_ren === 1'b1) begin
        line = dram_mem.exists(int'(o_dram_addr >> 3)) ? dram_mem[int'(o_dram_addr >> 3)] : 128'h0;
        due = cycle + int'($urandom_range(1, 6));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_due.push_back(due);
        pend_dat.push_back(line);
      end
      if (i_valid && o_ready) begin
        acc_now = 1'b1;
        accepted++;
        word = ref_mem.exists(int'(i_addr[27:2])) ? ref_mem[int'(i_addr[27:2])] : 32'h0;
        if (i_wen) begin
          for (int b = 0; b < 4; b++)
            if (i_wstrb[b]) word[8*b +: 8] = i_wdata[8*b +: 8];
          ref_mem[int'(i_addr[27:2])] = word;
        end else begin
          exp_q.push_back(word);
        end
      end
      cyc();
      cycle++;
    end
    i_valid = 1'b0;
    i_dram_valid = 1'b0;
    i_dram_busy = 1'b0;
    checks++; if (accepted !== N || exp_q.size() != 0)
      begin errors++; $display("FAIL rand_complete got %0d accepted %0d pending want %0d 0", accepted, exp_q.size(), N); end
    checks++; if (viol_cnt - vbase !== 0)
      begin errors++; $display("FAIL rand_busy_violation got %0d want 0", viol_cnt - vbase); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rand_err got %b want 0", o_err); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_busy_hold();
    test_ofifo_full();
    test_err_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
